uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` serial transmitter between `N_REQ` byte-stream requesters using round-robin arbitration. Each requester offers bytes on a valid/ready interface. The arbiter drives the transmitter's level-style `tx_data`/`tx_send` handshake: assert `tx_send` until the transmitter leaves idle, then deassert it so the transmitter can return to idle. It sits between on-chip message sources (status, debug, echo) and the single board UART pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
package uart_pkg;

    localparam int unsigned CLK_FRQ   = 27000000;
    localparam int unsigned BAUD_RATE = 115200;
    localparam int unsigned CYCLE     = CLK_FRQ / BAUD_RATE;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the level-style transmitter handshake.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    import uart_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]       tx_data;
    logic                    tx_send;
    logic                    tx_ready;
    logic [IDX_W-1:0]        grant_id;
    logic                    busy;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_send, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_send, grant_id, busy
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first eligible request at or after ptr.
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!any && req[cand] && mask[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte streams.
// Optional message lock (no interleaving) via `UART_ARB_MSG_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_send_q, tx_send_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  win_gnt;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    logic [BYTE_W-1:0] win_byte;
    logic [IDX_W-1:0]  rr_adv;

`ifdef UART_ARB_MSG_LOCK_EN
    logic             lock_act_q, lock_act_d;
    logic [IDX_W-1:0] lock_id_q, lock_id_d;

    always_comb begin
        elig = '1;
        if (lock_act_q) begin
            elig = N_REQ'(1) << lock_id_q;
        end
    end
`else
    assign elig = '1;
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (bus.req_valid),
        .mask (elig),
        .ptr  (rr_ptr_q),
        .gnt  (win_gnt),
        .idx  (win_idx),
        .any  (win_any)
    );

    assign rr_adv = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = tx_send_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        req_ready  = '0;
        win_byte   = '0;
`ifdef UART_ARB_MSG_LOCK_EN
        lock_act_d = lock_act_q;
        lock_id_d  = lock_id_q;
`endif
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) begin
                win_byte = bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end

        unique case (state_q)
            S_ARB: begin
                // Reset gating keeps req_ready low while the transmitter may still be mid-frame.
                if (!reset && bus.tx_ready && win_any) begin
                    req_ready  = win_gnt;
                    tx_data_d  = win_byte;
                    tx_send_d  = 1'b1;
                    grant_id_d = win_idx;
                    state_d    = S_SEND;
`ifdef UART_ARB_MSG_LOCK_EN
                    if (bus.req_last[win_idx]) begin
                        lock_act_d = 1'b0;
                        rr_ptr_d   = rr_adv;
                    end else begin
                        lock_act_d = 1'b1;
                        lock_id_d  = win_idx;
                    end
`else
                    rr_ptr_d = rr_adv;
`endif
                end
            end
            S_SEND: begin
                if (!bus.tx_ready) begin
                    tx_send_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.tx_ready) begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_ARB;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
`ifdef UART_ARB_MSG_LOCK_EN
            lock_act_q <= 1'b0;
            lock_id_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef UART_ARB_MSG_LOCK_EN
            lock_act_q <= lock_act_d;
            lock_id_q  <= lock_id_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != S_ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter, per-cycle reference model, directed + random traffic.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned N          = 4;
    localparam int unsigned FRAME_FULL = 10 * CYCLE + 1;
    localparam int unsigned FRAME_FAST = 41;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Requester sources: {last, data} per entry.
    logic [8:0]   src_q [N][$];
    logic [N-1:0] en        = '1;
    bit           gate_rand = 1'b0;
    logic [N-1:0] acc_vec   = '0;

    // Reference model state.
    int         m_phase   = 0;
    logic       m_send    = 1'b0;
    logic [7:0] m_data    = 8'h00;
    int         m_gid     = 0;
    int         m_ptr     = 0;
    bit         m_lock    = 1'b0;
    int         m_lock_id = 0;
    logic [7:0] exp_line [$];
    int         rdy_cnt [N];
    int         busy_rdy_bad = 0;

    // Transmitter model state.
    logic [7:0] line_log [$];
    int         frame_len = FRAME_FULL;
    bit         tx_idle   = 1'b1;
    int         tx_cnt    = 0;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    bus.req_data[i*8 +: 8] = src_q[i][0][7:0];
                    bus.req_last[i]        = src_q[i][0][8];
                end
                bus.req_valid[i] = en[i] && (src_q[i].size() > 0) &&
                                   (!gate_rand || ($urandom_range(0, 1) == 1));
            end
            acc_vec = '0;
        end
    end

    // Transmitter: latches on tx_send while idle, busy for frame_len edges, idles only once tx_send is low.
    initial begin
        logic       s;
        logic [7:0] d;
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            s = bus.tx_send;
            d = bus.tx_data;
            #1;
            if (tx_idle) begin
                if (s) begin
                    tx_idle = 1'b0;
                    tx_cnt  = frame_len;
                    line_log.push_back(d);
                    if (exp_line.size() == 0) chk("line_spurious_frame", 32'(d), 32'hFFFF_FFFF);
                    else                      chk("line_byte", 32'(d), 32'(exp_line.pop_front()));
                    bus.tx_ready = 1'b0;
                end
            end else begin
                if (tx_cnt > 0) tx_cnt--;
                if (tx_cnt == 0 && !s) begin
                    tx_idle      = 1'b1;
                    bus.tx_ready = 1'b1;
                end
            end
        end
    end

    // Compare process: checks every output each cycle, then advances the model across the next edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           w;
        int           c;
        exp_rdy = '0;
        w       = -1;
        if (!reset && m_phase == 0 && bus.tx_ready) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && bus.req_valid[c] && (!m_lock || c == m_lock_id)) w = c;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("tx_send",   32'(bus.tx_send),   32'(m_send));
        chk("tx_data",   32'(bus.tx_data),   32'(m_data));
        chk("grant_id",  32'(bus.grant_id),  32'(m_gid));
        chk("busy",      32'(bus.busy),      32'(m_phase != 0));

        acc_vec = bus.req_valid & bus.req_ready;
        for (int i = 0; i < N; i++) rdy_cnt[i] += int'(bus.req_ready[i]);
        if (bus.busy && bus.req_ready != '0) busy_rdy_bad++;

        if (reset) begin
            m_phase = 0; m_send = 1'b0; m_data = 8'h00; m_gid = 0; m_ptr = 0; m_lock = 1'b0;
        end else begin
            case (m_phase)
                0: if (w >= 0) begin
                    m_data  = bus.req_data[w*8 +: 8];
                    m_send  = 1'b1;
                    m_gid   = w;
                    m_phase = 1;
                    exp_line.push_back(m_data);
`ifdef UART_ARB_MSG_LOCK_EN
                    if (bus.req_last[w]) begin
                        m_lock = 1'b0;
                        m_ptr  = (w + 1) % N;
                    end else begin
                        m_lock    = 1'b1;
                        m_lock_id = w;
                    end
`else
                    m_ptr = (w + 1) % N;
`endif
                end
                1: if (!bus.tx_ready) begin
                    m_send  = 1'b0;
                    m_phase = 2;
                end
                default: if (bus.tx_ready) m_phase = 0;
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        line_log.delete();
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int c;
        int pending;
        c = 0;
        forever begin
            pending = 0;
            for (int i = 0; i < N; i++) if (en[i]) pending += src_q[i].size();
            if ((pending == 0 && m_phase == 0 && tx_idle) || c >= max_cyc) break;
            @(negedge clk);
            c++;
        end
        chk(name, 32'(c < max_cyc), 32'd1);
    endtask

    task automatic wait_accept(input string name, input int max_cyc);
        int c;
        c = 0;
        while (bus.req_ready == '0 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(bus.req_ready != '0), 32'd1);
    endtask

    initial begin
        logic [7:0] e5 [5];
        logic [7:0] e3 [3];
        int         bad;
        int         c;

        // Reset state, with a requester valid while reset is held.
        src_q[0].push_back({1'b1, 8'h5A});
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        src_q[0].delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_send",  32'(bus.tx_send),  32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);

        // Single requester and handshake timing.
        frame_len = FRAME_FULL;
        do_reset();
        src_q[0].push_back({1'b1, 8'h55});
        @(negedge clk);
        wait_accept("single_accept", 20);
        @(negedge clk);
        chk("single_send_t1", 32'(bus.tx_send), 32'd1);
        @(negedge clk);
        chk("single_txready_t2", 32'(bus.tx_ready), 32'd0);
        chk("single_send_t2",    32'(bus.tx_send),  32'd1);
        @(negedge clk);
        chk("single_send_t3", 32'(bus.tx_send), 32'd0);
        wait_drain("single_drain", 3 * FRAME_FULL);
        chk("single_ready_pulses", 32'(rdy_cnt[0]), 32'd1);
        chk("single_line_count",   32'(line_log.size()), 32'd1);
        if (line_log.size() > 0) chk("single_line_byte", 32'(line_log[0]), 32'h55);

        // All four requesters busy: 0,1,2,3,0.
        do_reset();
        src_q[0].push_back({1'b1, 8'hA0});
        src_q[0].push_back({1'b1, 8'hA0});
        for (int i = 1; i < N; i++) src_q[i].push_back({1'b1, 8'(8'hA0 + i)});
        e5 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        wait_drain("allbusy_drain", 6 * (FRAME_FULL + 10));
        chk("allbusy_count", 32'(line_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < line_log.size(); i++) chk("allbusy_order", 32'(line_log[i]), 32'(e5[i]));

        // Message lock: req 1 sends three bytes while req 2 waits.
        do_reset();
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b1, 8'h13});
        src_q[2].push_back({1'b1, 8'h21});
        src_q[2].push_back({1'b1, 8'h22});
`ifdef UART_ARB_MSG_LOCK_EN
        e5 = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22};
`else
        e5 = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13};
`endif
        wait_drain("lock_drain", 6 * (FRAME_FULL + 10));
        chk("lock_count", 32'(line_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < line_log.size(); i++) chk("lock_order", 32'(line_log[i]), 32'(e5[i]));

        // Reset while the arbiter holds tx_send high.
        do_reset();
        src_q[0].push_back({1'b1, 8'h77});
        src_q[1].push_back({1'b1, 8'h88});
        @(negedge clk);
        wait_accept("rstmid_accept", 20);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        bad = 0;
        c   = 0;
        @(negedge clk);
        while (!bus.tx_ready && c < 2 * FRAME_FULL) begin
            if (bus.tx_send || bus.req_ready != '0) bad++;
            @(negedge clk);
            c++;
        end
        chk("rstmid_quiet_until_ready", 32'(bad), 32'd0);
        wait_drain("rstmid_drain", 4 * FRAME_FULL);
        chk("rstmid_count", 32'(line_log.size()), 32'd2);
        e3 = '{8'h77, 8'h88, 8'h00};
        for (int i = 0; i < 2 && i < line_log.size(); i++) chk("rstmid_order", 32'(line_log[i]), 32'(e3[i]));

        // Withdrawn request from req 3 while the transmitter is busy.
        do_reset();
        en[3] = 1'b0;
        src_q[0].push_back({1'b1, 8'h31});
        c = 0;
        while (bus.tx_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("withdraw_tx_started", 32'(bus.tx_ready), 32'd0);
        src_q[3].push_back({1'b1, 8'hC3});
        en[3] = 1'b1;
        @(negedge clk);
        chk("withdraw_valid_up", 32'(bus.req_valid[3]), 32'd1);
        en[3] = 1'b0;
        src_q[3].delete();
        src_q[0].push_back({1'b1, 8'hA0});
        src_q[2].push_back({1'b1, 8'hA2});
        wait_drain("withdraw_drain", 4 * (FRAME_FULL + 10));
        chk("withdraw_no_ready3", 32'(rdy_cnt[3]), 32'd0);
        chk("withdraw_count", 32'(line_log.size()), 32'd3);
        e3 = '{8'h31, 8'hA2, 8'hA0};
        for (int i = 0; i < 3 && i < line_log.size(); i++) chk("withdraw_order", 32'(line_log[i]), 32'(e3[i]));
        en[3] = 1'b1;

        // Pointer wrap: reach rr_ptr=3, then req 3 and req 0 compete.
        do_reset();
        src_q[2].push_back({1'b1, 8'h02});
        @(negedge clk);
        wait_accept("wrap_first_accept", 20);
        src_q[3].push_back({1'b1, 8'hD3});
        src_q[0].push_back({1'b1, 8'hD0});
        wait_drain("wrap_drain", 4 * (FRAME_FULL + 10));
        chk("wrap_count", 32'(line_log.size()), 32'd3);
        e3 = '{8'h02, 8'hD3, 8'hD0};
        for (int i = 0; i < 3 && i < line_log.size(); i++) chk("wrap_order", 32'(line_log[i]), 32'(e3[i]));

        // Randomized traffic with a short frame and random valid gating.
        frame_len = FRAME_FAST;
        do_reset();
        gate_rand = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 30; j++) begin
                src_q[i].push_back({(j == 29) || ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255))});
            end
        end
        wait_drain("random_drain", 30000);
        chk("random_count", 32'(line_log.size()), 32'd120);
        gate_rand = 1'b0;

        repeat (5) @(negedge clk);
        chk("exp_line_empty", 32'(exp_line.size()), 32'd0);
        chk("busy_ready_overlap", 32'(busy_rdy_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
